// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// hands each returned word to the decoder through a one-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_instr, r_inst_pc;
  logic        r_kill, w_kill_nx;
  logic        r_fault, w_fault_nx;
  logic        w_latch;
  logic        w_misaligned;

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_kill_nx  = r_kill;
    w_fault_nx = r_fault;
    w_latch    = 1'b0;
    if (redirect_valid && (r_state != HALT)) begin
      if (w_misaligned) begin
        w_fault_nx = 1'b1;
        w_state_nx = HALT;
      end else begin
        w_pc_nx = redirect_pc;
        case (r_state)
          // An accepted old-address request still has a response coming back
          REQ: begin
            if (imem_ready) begin
              w_state_nx = WAIT;
              w_kill_nx  = 1'b1;
            end else begin
              w_state_nx = REQ;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              w_state_nx = REQ;
              w_kill_nx  = 1'b0;
            end else begin
              w_kill_nx  = 1'b1;
            end
          end
          default: w_state_nx = REQ;
        endcase
      end
    end else begin
      case (r_state)
        IDLE: w_state_nx = REQ;
        REQ:  if (imem_ready) w_state_nx = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              w_kill_nx  = 1'b0;
              w_state_nx = REQ;
            end else begin
              w_latch    = 1'b1;
              w_pc_nx    = r_pc + 32'd4;
              w_state_nx = HOLD;
            end
          end
        end
        HOLD:    if (inst_ready) w_state_nx = REQ;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_fault   <= 1'b0;
      r_instr   <= 32'd0;
      r_inst_pc <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_kill  <= w_kill_nx;
      r_fault <= w_fault_nx;
      if (w_latch) begin
        r_instr   <= imem_rdata;
        r_inst_pc <= r_pc;
      end
    end
  end

  assign imem_req      = (r_state == REQ);
  assign imem_addr     = r_pc;
  assign inst_valid    = (r_state == HOLD);
  assign instruction   = r_instr;
  assign inst_pc       = r_inst_pc;
  assign inst_pc_plus4 = r_inst_pc + 32'd4;
  assign fetch_fault   = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a memory responder and an
// expected-PC-stream model of what the decoder should receive.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc = RST_PC;
  bit          halted_m = 0;
  bit          pending = 0;
  logic [31:0] pend_addr = 0;
  int          pend_dly = 0;
  int          lat = 0;
  bit          lat_rand = 0;
  bit          saw_valid;
  int          guard;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: apply model rules for the upcoming edge, then advance and
  // let the memory responder drive rvalid for the following cycle.
  task automatic cyc();
    bit mis;
    if (halted_m) begin
      chk("halt_no_req", {31'b0, imem_req}, 32'd0);
      chk("halt_no_valid", {31'b0, inst_valid}, 32'd0);
    end
    if (rst) begin
      exp_pc = RST_PC; halted_m = 0; pending = 0;
    end else begin
      mis = !halted_m && redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (!halted_m && redirect_valid) begin
        if (mis) halted_m = 1;
        else exp_pc = redirect_pc;
      end else if (!halted_m && inst_valid && inst_ready) begin
        chk("deliv_pc", inst_pc, exp_pc);
        chk("deliv_word", instruction, mem_word(exp_pc));
        chk("deliv_plus4", inst_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (imem_rvalid) pending = 0;
      if (imem_req && imem_ready && !mis) begin
        chk("one_outstanding", {31'b0, pending}, 32'd0);
        pending = 1; pend_addr = imem_addr;
        pend_dly = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end
    end
    @(posedge clk); #1;
    if (pending && pend_dly == 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      if (pending) pend_dly--;
    end
  endtask

  initial begin
    rst = 1; imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 1;
    cyc(); cyc(); cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_plus4", inst_pc_plus4, 32'd4);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Zero-wait streaming: 3-cycle cadence
    rst = 0;
    chk("first_cycle_no_req", {31'b0, imem_req}, 32'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("stream_req", {31'b0, imem_req}, 32'd1);
      chk("stream_addr", imem_addr, RST_PC + 32'(4 * k));
      cyc();
      chk("stream_wait_valid", {31'b0, inst_valid}, 32'd0);
      cyc();
      chk("stream_valid", {31'b0, inst_valid}, 32'd1);
      chk("stream_pc", inst_pc, RST_PC + 32'(4 * k));
      chk("stream_plus4", inst_pc_plus4, RST_PC + 32'(4 * k + 4));
      chk("stream_word", instruction, mem_word(RST_PC + 32'(4 * k)));
      cyc();
    end

    // Backpressure on word 0x10C
    inst_ready = 0;
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_pc", inst_pc, 32'h10C);
      chk("bp_word", instruction, mem_word(32'h10C));
      chk("bp_no_req", {31'b0, imem_req}, 32'd0);
    end
    inst_ready = 1;
    cyc();
    chk("bp_release_req", {31'b0, imem_req}, 32'd1);
    chk("bp_release_addr", imem_addr, 32'h110);

    // Redirect while waiting on a slow response
    lat = 2;
    cyc();
    lat = 0;
    redirect_valid = 1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 0;
    saw_valid = 0; guard = 0;
    while (!imem_req && guard < 10) begin
      if (inst_valid) saw_valid = 1;
      cyc(); guard++;
    end
    chk("wait_redir_bounded", {31'b0, imem_req}, 32'd1);
    chk("wait_redir_no_stale", {31'b0, saw_valid}, 32'd0);
    chk("wait_redir_addr", imem_addr, 32'h200);
    cyc(); cyc();
    chk("wait_redir_valid", {31'b0, inst_valid}, 32'd1);
    chk("wait_redir_pc", inst_pc, 32'h200);
    cyc();

    // Redirect in HOLD while the decoder is also accepting
    cyc(); cyc();
    chk("hold_pc", inst_pc, 32'h204);
    redirect_valid = 1; redirect_pc = 32'h300;
    cyc();
    redirect_valid = 0;
    chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h300);
    chk("hold_redir_valid", {31'b0, inst_valid}, 32'd0);

    // Redirect in REQ while memory stalls
    imem_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h340;
    cyc();
    redirect_valid = 0;
    chk("req_redir_addr", imem_addr, 32'h340);
    cyc();
    chk("req_redir_hold_addr", imem_addr, 32'h340);
    imem_ready = 1;
    cyc(); cyc();
    chk("req_redir_valid", {31'b0, inst_valid}, 32'd1);
    chk("req_redir_pc", inst_pc, 32'h340);
    cyc();

    // Wrap-around through an accepted-then-killed request
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 0;
    guard = 0;
    while (!imem_req && guard < 10) begin cyc(); guard++; end
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(); cyc();
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", inst_pc_plus4, 32'h0);
    cyc();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_req", {31'b0, imem_req}, 32'd1);

    // Misaligned redirect halts until reset
    redirect_valid = 1; redirect_pc = 32'h202;
    cyc();
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    redirect_pc = 32'h400;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("halt_fault_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    redirect_valid = 0;
    rst = 1;
    cyc();
    chk("rst_clear_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_restart_addr", imem_addr, RST_PC);
    rst = 0;
    cyc();
    chk("restart_req", {31'b0, imem_req}, 32'd1);

    // Randomized traffic checked against the expected PC stream
    lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      imem_ready     = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      cyc();
    end
    chk("rand_deliveries", {31'b0, (n_deliv > 150)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Holds the program counter and issues one word-aligned read at a time to instruction memory over a req/ready + rvalid handshake. Presents each returned word with its PC to the decoder through a one-entry valid/ready buffer. Accepts PC redirects from branch/jump resolution, discarding any in-flight or buffered stale instruction.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request valid.
- imem_addr  out  32  read address; always equals current pc.
- imem_ready  in  1  memory accepts the request this cycle (handshake when imem_req && imem_ready).
- imem_rvalid  in  1  read data valid; at most one per accepted request, no earlier than the cycle after acceptance.
- imem_rdata  in  32  read data.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  32  new PC target.
- instruction  out  32  fetched word, to decoder.
- inst_pc  out  32  address of instruction.
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32 (link value for JAL/JALR).
- inst_valid  out  1  instruction/inst_pc are valid.
- inst_ready  in  1  downstream consumes the word (transfer when inst_valid && inst_ready).
- fetch_fault  out  1  sticky misaligned-redirect fault.

## Operation

- Registers: pc[31:0], state, kill flag, output buffer (instruction, inst_pc, inst_valid), fetch_fault.
- States: IDLE, REQ, WAIT, HOLD, HALT. Outputs are Moore: imem_req = (state==REQ); inst_valid = (state==HOLD).
- IDLE: entered on rst. Moves to REQ on the first edge with rst low.
- REQ: imem_addr = pc. If imem_ready, move to WAIT; otherwise stay in REQ.
- WAIT: on imem_rvalid:
  - kill==1: drop the data, clear kill, move to REQ.
  - kill==0: latch instruction=imem_rdata and inst_pc=pc, set pc<=pc+4, move to HOLD.
- HOLD: if inst_ready, move to REQ. Otherwise hold the buffer stable; instruction and inst_pc must not change while inst_valid && !inst_ready.
- PC arithmetic: pc+4 wraps, so 32'hFFFF_FFFC → 32'h0000_0000. inst_pc_plus4 wraps identically.
- Redirect has priority over every transition except rst. It is taken when redirect_valid is sampled high in IDLE, REQ, WAIT or HOLD.
  - The target must be aligned, i.e. redirect_pc[1:0]==0. If it is not, set fetch_fault=1 and go to HALT. pc is not updated.
  - If aligned, pc<=redirect_pc and the next state depends on the current state:
    - IDLE/HOLD → REQ. The buffer is flushed and the unconsumed word is discarded, even if inst_ready was high that cycle.
    - REQ with imem_ready=0 → REQ. imem_addr changes to the new pc next cycle. This is the only case where the address may change while a request is pending.
    - REQ with imem_ready=1 → WAIT with kill=1. The old-address request was accepted.
    - WAIT with imem_rvalid=0 → WAIT with kill=1.
    - WAIT with imem_rvalid=1 → REQ. The data is dropped and kill is cleared.
- HALT: imem_req=0 and inst_valid=0. Ignores all inputs. Exits only via rst.
- Only one request is outstanding at any time. A new request is never issued while in WAIT.

## Timing

- Reset values: pc=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0, inst_pc_plus4=4, fetch_fault=0.
- rst asserted mid-operation aborts everything. Any later imem_rvalid arriving for a pre-reset request while in REQ is ignored; rvalid is only sampled in WAIT.
- After rst deasserts, imem_req first rises in the second cycle.
- Latency with zero wait states (imem_ready=1 on the first REQ cycle, rvalid in the next cycle):
  - REQ at cycle N, WAIT at N+1, inst_valid at N+2.
  - With inst_ready=1, the next REQ is at N+3, giving a 3-cycle throughput per instruction.
- Redirect to a valid instruction with zero-wait memory: the instruction from the new pc is valid 2 cycles after the next REQ cycle.

## Test plan

1. Reset with RESET_PC=0x100, memory zero-wait, inst_ready=1 → inst_valid pulses with inst_pc 0x100, 0x104, 0x108, every 3 cycles. inst_pc_plus4 is 0x104, 0x108, 0x10C. imem_req is low during reset and for the first cycle after.
2. Backpressure: inst_ready=0 for 5 cycles while the word at 0x104 is valid → instruction and inst_pc are stable and there are no new imem_req. Raising inst_ready produces the REQ for 0x108 the next cycle.
3. Redirect in WAIT: request for 0x108 is accepted, redirect_pc=0x200, rvalid returns 3 cycles later with 0xDEADBEEF → the word is dropped and never valid. The next request address is 0x200 and the first inst_pc is 0x200.
4. Redirect in HOLD with inst_ready=1 in the same cycle → the buffered word is discarded and the next imem_addr is the redirect target. Redirect in REQ with imem_ready=0 → imem_addr switches to the target and no kill occurs.
5. Wrap-around: redirect to 0xFFFF_FFFC → inst_pc 0xFFFF_FFFC with inst_pc_plus4 0x0, and the next fetch address is 0x0000_0000.
6. Misaligned redirect_pc=0x202 → fetch_fault=1 and HALT: no further imem_req, inst_valid=0, even with redirect_valid. rst clears the fault and restarts at RESET_PC.
